// File: rtl/ex_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - R-type ALU op encoding and the HI/LO-related funct codes
//   - FSM state enumeration for the iterative controller
//   - default operand width and the last iteration index
//   - magnitude() helper used to strip signs before iterating
// ----------------------------------------------------------------------------
package ex_muldiv_pkg;

    // Operand / HI / LO width. Only 32 is supported.
    localparam int DATA_W_DEFAULT = 32;

    // ALU op class that qualifies the funct decode.
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    // funct field codes handled by this unit.
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Index of the final shift-add / restoring-subtract step.
    localparam logic [4:0] LAST_STEP = 5'd31;

    // Controller states: idle, iterating multiply, iterating divide,
    // and the single sign-fix / HI-LO write-back cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Absolute value of a two's-complement operand when is_signed is set;
    // pass-through otherwise. 0x8000_0000 maps onto itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        is_signed);
        return (is_signed && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// ----------------------------------------------------------------------------
// muldiv_core
// 64-bit accumulator datapath for the iterative multiply/divide unit.
// Works purely on unsigned magnitudes; sign handling lives in the controller.
//
// Multiply (shift-add): acc = {0, multiplier}; each step adds the
// multiplicand into the upper half when acc[0] is set, then shifts the
// 65-bit {carry, acc} right by one. After 32 steps acc holds the product.
//
// Divide (restoring): acc = {0, dividend}; each step shifts acc left by one
// and tries to subtract the divisor from the upper half. On success the
// difference replaces the upper half and a quotient 1 enters at bit 0.
// After 32 steps acc = {remainder, quotient}.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   load_i    in   load operands and mode (takes priority over step_i)
//   step_i    in   perform one iteration
//   is_div_i  in   mode for the load: 1 = divide, 0 = multiply
//   a_mag_i   in   multiplicand / dividend magnitude
//   b_mag_i   in   multiplier / divisor magnitude
//   acc_o     out  accumulator ({HI, LO} shaped result after 32 steps)
// ----------------------------------------------------------------------------
module muldiv_core #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                is_div_i,
    input  logic [DATA_W-1:0]   a_mag_i,
    input  logic [DATA_W-1:0]   b_mag_i,
    output logic [2*DATA_W-1:0] acc_o
);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [DATA_W-1:0]   opnd_q;       // multiplicand or divisor
    logic                div_mode_q;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;

    always_comb begin
        // Shift-add step: the carry out of the add becomes the new MSB.
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        // Restoring step: the trial window is the upper half shifted left
        // with the next dividend bit appended (DATA_W+1 bits). A borrow in
        // the MSB of the difference means the divisor did not fit; in that
        // case the window was below the divisor, so acc_q's MSB is zero and
        // the plain left shift loses nothing.
        div_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_q};
        if (div_diff[DATA_W]) begin
            div_next = {acc_q[2*DATA_W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end

        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{DATA_W{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
        end else if (step_i) begin
            acc_d = div_mode_q ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            div_mode_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opnd_q     <= is_div_i ? b_mag_i : a_mag_i;
                div_mode_q <= is_div_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// ex_muldiv_ctrl
// EX-stage controller for MULT/MULTU/DIV/DIVU and the HI/LO moves.
// Decodes the EX instruction, runs a 32-step iterative multiply/divide in
// muldiv_core, applies signs in a final FIX cycle, owns HI/LO and raises a
// pipeline stall whenever a HI/LO-related instruction meets a busy unit.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   id_ex_instr   in   EX instruction, funct = [5:0]
//   id_ex_alu_op  in   ALU op class, 2'b10 = R-type
//   id_ex_valid   in   EX slot holds a real instruction
//   flush         in   EX instruction squashed this cycle
//   operand_a     in   forwarded rs value
//   operand_b     in   forwarded rt value
//   stall         out  hold IF/ID/EX, bubble EX/MEM
//   busy          out  iterative operation in progress
//   hi, lo        out  architectural HI/LO
//   mf_result     out  MFHI/MFLO read data (0 otherwise / while stalled)
//   div_zero      out  last completed divide had a zero divisor (sticky)
// ----------------------------------------------------------------------------
module ex_muldiv_ctrl
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_ex_instr,
    input  logic [1:0]        id_ex_alu_op,
    input  logic              id_ex_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mf_result,
    output logic              div_zero
);

    // ---------------------------------------------------------------- decode
    logic [5:0] funct;
    logic       dec_rtype;
    logic       dec_mult;
    logic       dec_multu;
    logic       dec_div;
    logic       dec_divu;
    logic       dec_mfhi;
    logic       dec_mflo;
    logic       dec_mthi;
    logic       dec_mtlo;
    logic       dec_md;
    logic       dec_any;
    logic       unused_instr_bits;

    assign funct     = id_ex_instr[5:0];
    assign dec_rtype = id_ex_valid && (id_ex_alu_op == ALU_OP_RTYPE);
    assign dec_mult  = dec_rtype && (funct == FUNCT_MULT);
    assign dec_multu = dec_rtype && (funct == FUNCT_MULTU);
    assign dec_div   = dec_rtype && (funct == FUNCT_DIV);
    assign dec_divu  = dec_rtype && (funct == FUNCT_DIVU);
    assign dec_mfhi  = dec_rtype && (funct == FUNCT_MFHI);
    assign dec_mflo  = dec_rtype && (funct == FUNCT_MFLO);
    assign dec_mthi  = dec_rtype && (funct == FUNCT_MTHI);
    assign dec_mtlo  = dec_rtype && (funct == FUNCT_MTLO);
    assign dec_md    = dec_mult | dec_multu | dec_div | dec_divu;
    assign dec_any   = dec_md | dec_mfhi | dec_mflo | dec_mthi | dec_mtlo;

    // Only the funct field matters to this unit.
    assign unused_instr_bits = ^id_ex_instr[31:6];

    // ------------------------------------------------------ operand prep
    logic              op_signed;
    logic              op_is_div;
    logic              divisor_zero;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              accept;
    logic              mt_write;

    assign op_signed    = dec_mult | dec_div;
    assign op_is_div    = dec_div | dec_divu;
    assign divisor_zero = (operand_b == '0);
    assign a_neg        = op_signed & operand_a[DATA_W-1];
    assign b_neg        = op_signed & operand_b[DATA_W-1];
    assign a_mag        = magnitude(operand_a, op_signed);
    assign b_mag        = magnitude(operand_b, op_signed);

    // A stalled md op is by definition not accepted; a flushed one never is.
    assign accept   = dec_md & ~stall & ~flush;
    assign mt_write = (dec_mthi | dec_mtlo) & ~stall & ~flush;

    // ------------------------------------------------------------- state
    state_t            state_q;
    state_t            state_d;
    logic [4:0]        cnt_q;
    logic [4:0]        cnt_d;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_d;
    logic              dz_q;
    logic              dz_d;

    // Attributes of the accepted op, consumed in FIX.
    logic              is_div_q;
    logic              zero_div_q;
    logic              neg_q;        // product / quotient needs negation
    logic              rem_neg_q;    // remainder follows the dividend sign
    logic [DATA_W-1:0] a_raw_q;      // HI value for divide-by-zero

    logic                core_load;
    logic                core_step;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    muldiv_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst_ni   (reset),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (op_is_div),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .acc_o    (acc)
    );

    assign prod_fix = neg_q     ? -acc                  : acc;
    assign quo_fix  = neg_q     ? -acc[DATA_W-1:0]      : acc[DATA_W-1:0];
    assign rem_fix  = rem_neg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    // --------------------------------------------- next-state / datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        core_load = 1'b0;
        core_step = 1'b0;

        // MTHI/MTLO only get through while idle (busy stalls them).
        if (mt_write && dec_mthi) begin
            hi_d = operand_a;
        end
        if (mt_write && dec_mtlo) begin
            lo_d = operand_a;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    core_load = 1'b1;
                    cnt_d     = '0;
                    dz_d      = 1'b0;
                    if (!op_is_div) begin
                        state_d = MUL;
                    end else if (divisor_zero) begin
                        state_d = FIX;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL, DIV: begin
                core_step = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                if (zero_div_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q   <= 1'b0;
            zero_div_q <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            a_raw_q    <= '0;
        end else if (accept) begin
            is_div_q   <= op_is_div;
            zero_div_q <= op_is_div & divisor_zero;
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            a_raw_q    <= operand_a;
        end
    end

    // ----------------------------------------------------------- outputs
    assign busy     = (state_q != IDLE);
    assign stall    = busy & dec_any;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

    // Reads are suppressed while stalled so a held MFHI/MFLO never leaks a
    // stale value toward MEM.
    always_comb begin
        mf_result = '0;
        if (!stall && dec_mfhi) begin
            mf_result = hi_q;
        end else if (!stall && dec_mflo) begin
            mf_result = lo_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_ctrl
// Self-checking bench: a transaction-level model (64-bit arithmetic plus a
// busy countdown) predicts stall/busy/hi/lo/mf_result/div_zero each cycle.
// Directed scenarios pin the model with hand-computed values, then random
// traffic runs against the model.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_ctrl;

    localparam logic [1:0] RT    = 2'b10;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] id_ex_instr = '0;
    logic [1:0]  id_ex_alu_op = '0;
    logic        id_ex_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_result;
    logic        div_zero;

    always #5 clk = ~clk;

    ex_muldiv_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_ex_instr  (id_ex_instr),
        .id_ex_alu_op (id_ex_alu_op),
        .id_ex_valid  (id_ex_valid),
        .flush        (flush),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .stall        (stall),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo),
        .mf_result    (mf_result),
        .div_zero     (div_zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: architectural values, cycles of busy left, and the
    // result waiting to land when the countdown expires.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dz, p_dz;
    int          m_rem;

    // Samples of the DUT taken by the per-cycle compare.
    logic        s_stall, s_busy, s_dz;
    logic [31:0] s_hi, s_lo, s_mf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hi = '0; m_lo = '0; m_dz = 1'b0; m_rem = 0;
        p_hi = '0; p_lo = '0; p_dz = 1'b0;
    endtask

    task automatic expected(output logic e_stall, output logic [31:0] e_mf);
        logic       rt;
        logic [5:0] f;
        logic       known;
        rt    = id_ex_valid && (id_ex_alu_op == RT);
        f     = id_ex_instr[5:0];
        known = rt && (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                 F_MULT, F_MULTU, F_DIV, F_DIVU});
        e_stall = (m_rem > 0) && known;
        e_mf    = '0;
        if (!e_stall && rt && f == F_MFHI) e_mf = m_hi;
        if (!e_stall && rt && f == F_MFLO) e_mf = m_lo;
    endtask

    task automatic compare_cycle();
        logic        e_stall;
        logic [31:0] e_mf;
        expected(e_stall, e_mf);
        s_stall = stall; s_busy = busy; s_dz = div_zero;
        s_hi = hi; s_lo = lo; s_mf = mf_result;
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("mf_result", mf_result, e_mf);
        chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
    endtask

    // Advance the model across one rising edge using the held inputs.
    task automatic model_edge();
        logic        e_stall;
        logic [31:0] e_mf;
        logic        rt;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] x, y, p;
        longint      sa, sb, q, r;
        if (!reset) begin
            model_clear();
            return;
        end
        expected(e_stall, e_mf);
        rt = id_ex_valid && (id_ex_alu_op == RT);
        f  = id_ex_instr[5:0];
        a  = operand_a;
        b  = operand_b;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
        end else if (rt && !flush && !e_stall) begin
            if (f == F_MTHI) m_hi = a;
            if (f == F_MTLO) m_lo = a;
            if (f == F_MULT || f == F_MULTU) begin
                if (f == F_MULT) begin
                    x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b};
                end else begin
                    x = {32'b0, a}; y = {32'b0, b};
                end
                p = x * y;
                p_hi = p[63:32]; p_lo = p[31:0]; p_dz = 1'b0;
                m_rem = 33; m_dz = 1'b0;
            end
            if (f == F_DIV || f == F_DIVU) begin
                m_dz = 1'b0;
                if (b == 32'd0) begin
                    p_hi = a; p_lo = 32'hFFFF_FFFF; p_dz = 1'b1; m_rem = 1;
                end else begin
                    if (f == F_DIV) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    p_lo = q[31:0]; p_hi = r[31:0]; p_dz = 1'b0; m_rem = 33;
                end
            end
            if (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO})
                $display("txn t=%0t funct=%h a=%h b=%h -> hi=%h lo=%h dz=%0d",
                         $time, f, a, b, (m_rem > 0) ? p_hi : m_hi,
                         (m_rem > 0) ? p_lo : m_lo, (m_rem > 0) ? p_dz : m_dz);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [1:0] aop,
                         input logic [5:0] f, input logic fl,
                         input logic [31:0] a, input logic [31:0] b);
        logic [25:0] upper;
        @(negedge clk);
        upper        = 26'($urandom());
        reset        = rst;
        id_ex_valid  = v;
        id_ex_alu_op = aop;
        id_ex_instr  = {upper, f};
        flush        = fl;
        operand_a    = a;
        operand_b    = b;
        if (!rst) model_clear();
        #1;
        compare_cycle();
        @(posedge clk);
        model_edge();
    endtask

    task automatic bubble();
        drive(1'b1, 1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, 1'b1, RT, f, 1'b0, a, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            bubble();
            if (s_busy) n++;
            else break;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          n;
        logic [5:0]  ftab [10];
        logic [5:0]  f;
        logic [1:0]  aop;
        logic        v, fl;

        model_clear();

        // Reset state.
        drive(1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, RT, F_MFHI, 1'b0, 32'h5, 32'h6);
        chk("rst_hi", s_hi, 32'h0);
        chk("rst_lo", s_lo, 32'h0);
        chk("rst_busy", {31'b0, s_busy}, 32'h0);

        // MULT -2 x 3.
        issue(F_MULT, 32'hFFFF_FFFE, 32'h3);
        chk("mult_issue_stall", {31'b0, s_stall}, 32'h0);
        wait_idle(n);
        chk("mult_busy_len", n, 33);
        chk("mult_hi", s_hi, 32'hFFFF_FFFF);
        chk("mult_lo", s_lo, 32'hFFFF_FFFA);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        // MULT followed immediately by MFLO.
        issue(F_MULT, 32'h5, 32'h7);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, RT, F_MFLO, 1'b0, 32'h0, 32'h0);
            if (s_stall) n++;
            else break;
        end
        chk("mflo_stall_len", n, 33);
        chk("mflo_result", s_mf, 32'd35);

        // DIV -7 / 2.
        issue(F_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_idle(n);
        chk("div_lo", s_lo, 32'hFFFF_FFFD);
        chk("div_hi", s_hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0.
        issue(F_DIVU, 32'h7, 32'h0);
        wait_idle(n);
        chk("divz_busy_len", n, 1);
        chk("divz_lo", s_lo, 32'hFFFF_FFFF);
        chk("divz_hi", s_hi, 32'h7);
        chk("divz_flag", {31'b0, s_dz}, 32'h1);

        // Signed overflow divide.
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_lo", s_lo, 32'h8000_0000);
        chk("ovf_hi", s_hi, 32'h0);
        chk("ovf_flag", {31'b0, s_dz}, 32'h0);

        // Flushed DIVU is ignored; MTHI writes next cycle.
        drive(1'b1, 1'b1, RT, F_DIVU, 1'b1, 32'h9, 32'h4);
        bubble();
        chk("flush_busy", {31'b0, s_busy}, 32'h0);
        chk("flush_lo", s_lo, 32'h8000_0000);
        drive(1'b1, 1'b1, RT, F_MTHI, 1'b0, 32'h1234, 32'h0);
        bubble();
        chk("mthi_hi", s_hi, 32'h1234);

        // Reset in the middle of MULTU.
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 15; i++) bubble();
        drive(1'b0, 1'b1, RT, F_MFLO, 1'b0, 32'h0, 32'h0);
        chk("midrst_busy", {31'b0, s_busy}, 32'h0);
        chk("midrst_stall", {31'b0, s_stall}, 32'h0);
        chk("midrst_hi", s_hi, 32'h0);
        chk("midrst_lo", s_lo, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) bubble();
        chk("postrst_hi", s_hi, 32'h0);
        chk("postrst_lo", s_lo, 32'h0);

        // Random traffic against the model.
        ftab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO,
                 F_MTHI, F_MTLO, 6'h20, 6'h2A};
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 99) < 85);
            aop = ($urandom_range(0, 9) < 8) ? RT : 2'($urandom_range(0, 3));
            f   = ftab[$urandom_range(0, 9)];
            fl  = ($urandom_range(0, 9) == 0);
            drive(1'b1, v, aop, f, fl, rand_operand(), rand_operand());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, operand/HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_ex_instr  input  32  EX-stage instruction; funct = [5:0].
REQ-005 id_ex_alu_op  input  2  2'b10 = R-type; muldiv decode is qualified by it.
REQ-006 id_ex_valid  input  1  EX slot holds a real (non-bubble) instruction.
REQ-007 flush  input  1  EX instruction is being squashed this cycle.
REQ-008 operand_a / operand_b  input  32 each  forwarded rs / rt values (post forwarding mux).
REQ-009 stall  output  1  hold IF/ID/EX and bubble EX/MEM this cycle.
REQ-010 busy  output  1  iterative multiply/divide in progress.
REQ-011 hi / lo  output  32 each  architectural HI/LO registers.
REQ-012 mf_result  output  32  MFHI/MFLO read data to EX/MEM result path.
REQ-013 div_zero  output  1  last completed DIV/DIVU had divisor 0; sticky until the next accepted MULT/DIV.

Function
REQ-014 Decode when id_ex_valid & id_ex_alu_op==2'b10: funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU (md ops), 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO; other funct ignored.
REQ-015 stall = busy & (md | MFHI | MFLO | MTHI | MTLO) decoded; combinational; otherwise 0.
REQ-016 Accept: md op with stall=0 and flush=0 latches operands and funct at the edge; flush=1 blocks accept and MT writes.
REQ-017 FSM states IDLE, MUL, DIV, FIX; IDLE->MUL (MULT/MULTU), IDLE->DIV (DIV/DIVU, divisor!=0), IDLE->FIX (divisor==0).
REQ-018 MUL/DIV: 5-bit counter from 0, one shift-add (MUL) or restoring-subtract (DIV) step per cycle; after step 31 -> FIX.
REQ-019 Signed ops iterate on magnitudes; FIX applies sign: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-020 FIX writes HI/LO (MUL: HI=upper 32, LO=lower 32; DIV: HI=remainder, LO=quotient) -> IDLE.
REQ-021 Latency: accept at edge E0, HI/LO valid after edge E33 (E1 when divisor 0); busy=1 from after E0 until E33.
REQ-022 Divide by zero: LO=32'hFFFF_FFFF, HI=operand_a, div_zero=1.
REQ-023 DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0, no flag.
REQ-024 MTHI/MTLO with stall=0, flush=0: write operand_a to HI/LO at the edge; 1-cycle, no FSM entry.
REQ-025 mf_result = hi for MFHI, lo for MFLO, else 0; valid only when stall=0.
REQ-026 flush while busy does not abort the running op (already retired from EX).
REQ-027 Back-to-back md ops: second op stalls until busy falls, is accepted in the cycle after E33.

Reset
REQ-028 reset low asynchronously forces state=IDLE, counter=0, hi=0, lo=0, div_zero=0, busy=0, stall=0, mf_result=0; operation in progress is discarded.
REQ-029 Exit from reset is synchronous to clk; first accept possible on the first edge with reset high.

Structure
REQ-030 Package ex_muldiv_pkg holds funct constants, ALU_OP_RTYPE (2'b10), state enum, DATA_W default.
REQ-031 Sub-module muldiv_core holds the 64-bit shift/accumulator datapath and one-step logic; ex_muldiv_ctrl holds decode, FSM, counter, HI/LO, stall.

Verification
REQ-032 MULT 0xFFFF_FFFE x 3 -> stall=0 at issue, busy 33 cycles, HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
REQ-033 MULT then immediate MFLO -> stall=1 for 33 cycles, then mf_result=LO of product; no MEM write during stall.
REQ-034 DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 7 / 0 -> LO=0xFFFF_FFFF, HI=7, div_zero=1, busy 1 cycle.
REQ-035 DIVU issued with flush=1 -> no accept, busy stays 0, HI/LO unchanged; MTHI 0x1234 -> HI=0x1234 next cycle.
REQ-036 reset low at iteration 15 of MULTU -> all outputs 0 immediately, no HI/LO update after release.
